jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl_if.sv | 24 ++
 rtl/jtag_tap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_ctrl_if.sv
// JTAG pin and user-register bundle between the TAP controller and its host.
interface jtag_tap_ctrl_if;
   logic        jtag_TCK;
   logic        jtag_TMS;
   logic        jtag_TDI;
   logic        jtag_TRSTn;
   logic        jtag_TDO_data;
   logic        jtag_TDO_driven;
   logic [31:0] user_dr;
   logic        user_update;
   logic [3:0]  tap_state;

   // Host side: drives the JTAG pins, observes TDO and the user register.
   modport master (
      output jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn,
      input  jtag_TDO_data, jtag_TDO_driven, user_dr, user_update, tap_state
   );

   // TAP side: samples the JTAG pins, drives TDO and the user register.
   modport slave (
      input  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn,
      output jtag_TDO_data, jtag_TDO_driven, user_dr, user_update, tap_state
   );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller oversampled on the system clock.
// JTAG pins are synchronized, TCK edges detected, and the TAP FSM, IR and
// DRs (IDCODE, USER, BYPASS) advance on detected TCK edges only.
module jtag_tap_ctrl #(
   parameter logic [31:0]        IDCODE  = 32'h0000_0001,
   parameter int unsigned        IR_LEN  = 5,
   parameter logic [IR_LEN-1:0]  USER_IR = IR_LEN'(5'h10)
) (
   input logic             clock,
   input logic             reset,
   jtag_tap_ctrl_if.slave  bus
);

   localparam int unsigned DR_LEN = 32;
   localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(1);
   localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

   typedef enum logic [3:0] {
      TLR      = 4'd0,
      RTI      = 4'd1,
      SEL_DR   = 4'd2,
      CAP_DR   = 4'd3,
      SH_DR    = 4'd4,
      EX1_DR   = 4'd5,
      PAUSE_DR = 4'd6,
      EX2_DR   = 4'd7,
      UPD_DR   = 4'd8,
      SEL_IR   = 4'd9,
      CAP_IR   = 4'd10,
      SH_IR    = 4'd11,
      EX1_IR   = 4'd12,
      PAUSE_IR = 4'd13,
      EX2_IR   = 4'd14,
      UPD_IR   = 4'd15
   } tap_state_t;

   // Standard TAP transition table.
   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TLR:      tap_next = tms ? TLR    : RTI;
         RTI:      tap_next = tms ? SEL_DR : RTI;
         SEL_DR:   tap_next = tms ? SEL_IR : CAP_DR;
         CAP_DR:   tap_next = tms ? EX1_DR : SH_DR;
         SH_DR:    tap_next = tms ? EX1_DR : SH_DR;
         EX1_DR:   tap_next = tms ? UPD_DR : PAUSE_DR;
         PAUSE_DR: tap_next = tms ? EX2_DR : PAUSE_DR;
         EX2_DR:   tap_next = tms ? UPD_DR : SH_DR;
         UPD_DR:   tap_next = tms ? SEL_DR : RTI;
         SEL_IR:   tap_next = tms ? TLR    : CAP_IR;
         CAP_IR:   tap_next = tms ? EX1_IR : SH_IR;
         SH_IR:    tap_next = tms ? EX1_IR : SH_IR;
         EX1_IR:   tap_next = tms ? UPD_IR : PAUSE_IR;
         PAUSE_IR: tap_next = tms ? EX2_IR : PAUSE_IR;
         EX2_IR:   tap_next = tms ? UPD_IR : SH_IR;
         UPD_IR:   tap_next = tms ? SEL_DR : RTI;
         default:  tap_next = TLR;
      endcase
   endfunction

   // Synchronizer stages; TMS/TDI use stage 2, aligned with tck_s2.
   logic tck_s1, tck_s2, tck_s3;
   logic tms_s1, tms_s2;
   logic tdi_s1, tdi_s2;
   logic trst_s1, trst_s2;

   tap_state_t          state;
   logic [IR_LEN-1:0]   ir;
   logic [IR_LEN-1:0]   ir_shift;
   logic [DR_LEN-1:0]   dr_shift;
   logic                bypass_q;
   logic [DR_LEN-1:0]   user_dr_q;
   logic                user_update_q;
   logic                tdo_data_q;
   logic                tdo_driven_q;
   logic [3:0]          tap_state_q;

   logic tck_rise_c, tck_fall_c;
   logic sel_idcode_c, sel_user_c, sel_bypass_c;
   logic dr_lsb_c;

   // TCK edge detect and DR selection decode.
   always_comb begin
      tck_rise_c   = tck_s2 & ~tck_s3;
      tck_fall_c   = ~tck_s2 & tck_s3;
      sel_idcode_c = (ir == IR_IDCODE);
      sel_user_c   = (ir == USER_IR) && !sel_idcode_c;
      sel_bypass_c = !sel_idcode_c && !sel_user_c;
      dr_lsb_c     = sel_bypass_c ? bypass_q : dr_shift[0];
   end

   // Synchronizers, TAP FSM, IR/DR shift paths and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         tck_s1        <= 1'b0;
         tck_s2        <= 1'b0;
         tck_s3        <= 1'b0;
         tms_s1        <= 1'b0;
         tms_s2        <= 1'b0;
         tdi_s1        <= 1'b0;
         tdi_s2        <= 1'b0;
         trst_s1       <= 1'b1;
         trst_s2       <= 1'b1;
         state         <= TLR;
         ir            <= IR_IDCODE;
         ir_shift      <= '0;
         dr_shift      <= '0;
         bypass_q      <= 1'b0;
         user_dr_q     <= '0;
         user_update_q <= 1'b0;
         tdo_data_q    <= 1'b0;
         tdo_driven_q  <= 1'b0;
         tap_state_q   <= 4'(TLR);
      end else begin
         tck_s1  <= bus.jtag_TCK;
         tck_s2  <= tck_s1;
         tck_s3  <= tck_s2;
         tms_s1  <= bus.jtag_TMS;
         tms_s2  <= tms_s1;
         tdi_s1  <= bus.jtag_TDI;
         tdi_s2  <= tdi_s1;
         trst_s1 <= bus.jtag_TRSTn;
         trst_s2 <= trst_s1;

         user_update_q <= 1'b0;

         if (!trst_s2) begin
            // Test reset dominates any TCK activity; user_dr is kept.
            state        <= TLR;
            ir           <= IR_IDCODE;
            ir_shift     <= '0;
            dr_shift     <= '0;
            bypass_q     <= 1'b0;
            tdo_driven_q <= 1'b0;
            tap_state_q  <= 4'(TLR);
         end else begin
            if (state == TLR) begin
               ir <= IR_IDCODE;
            end

            // Capture/shift keyed off the state before the transition.
            if (tck_rise_c) begin
               case (state)
                  CAP_IR: ir_shift <= IR_CAPTURE;
                  SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_LEN-1:1]};
                  CAP_DR: begin
                     if (sel_idcode_c)    dr_shift <= IDCODE;
                     else if (sel_user_c) dr_shift <= user_dr_q;
                     bypass_q <= 1'b0;
                  end
                  SH_DR: begin
                     if (sel_bypass_c) bypass_q <= tdi_s2;
                     else              dr_shift <= {tdi_s2, dr_shift[DR_LEN-1:1]};
                  end
                  default: ;
               endcase
               state <= tap_next(state, tms_s2);
            end

            // Updates and TDO launch on the falling TCK edge.
            if (tck_fall_c) begin
               if (state == UPD_IR) begin
                  ir <= ir_shift;
               end
               if (state == UPD_DR && sel_user_c) begin
                  user_dr_q     <= dr_shift;
                  user_update_q <= 1'b1;
               end
               tdo_data_q   <= (state == SH_IR) ? ir_shift[0] : dr_lsb_c;
               tdo_driven_q <= (state == SH_IR) || (state == SH_DR);
               tap_state_q  <= 4'(state);
            end
         end
      end
   end

   assign bus.jtag_TDO_data   = tdo_data_q;
   assign bus.jtag_TDO_driven = tdo_driven_q;
   assign bus.user_dr         = user_dr_q;
   assign bus.user_update     = user_update_q;
   assign bus.tap_state       = tap_state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: TAP walk, IDCODE, BYPASS, USER DR,
// TRST abort and static-TCK hold, all with hand-computed expectations.
module tb_jtag_tap_ctrl;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   int   upd_cnt;

   jtag_tap_ctrl_if bus ();

   jtag_tap_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts clocks with user_update high.
   always @(posedge clock) begin
      if (reset) upd_cnt <= 0;
      else if (bus.user_update) upd_cnt <= upd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full TCK period: rise with the given TMS/TDI, then fall; sample after.
   task automatic tck_cycle(input logic tms, input logic tdi);
      bus.jtag_TMS = tms;
      bus.jtag_TDI = tdi;
      bus.jtag_TCK = 1'b1;
      repeat (4) @(posedge clock);
      bus.jtag_TCK = 1'b0;
      repeat (4) @(posedge clock);
      #1;
   endtask

   // RTI -> Shift-IR/DR, scan n bits LSB first, update, back to RTI.
   task automatic scan(input bit is_ir, input logic [31:0] din, input int n,
                       input int hold, output logic [31:0] dout);
      dout = '0;
      tck_cycle(1'b1, 1'b0);
      if (is_ir) tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      dout[0] = bus.jtag_TDO_data;
      check("drv_in_shift", 32'(bus.jtag_TDO_driven), 32'd1);
      if (hold > 0) begin
         bus.jtag_TMS = 1'b1;
         for (int i = 0; i < hold; i++) begin
            bus.jtag_TDI = i[0];
            @(posedge clock);
         end
         #1;
         check("hold_state", 32'(bus.tap_state), is_ir ? 32'd11 : 32'd4);
         check("hold_tdo", 32'(bus.jtag_TDO_data), 32'(dout[0]));
      end
      for (int k = 1; k <= n; k++) begin
         tck_cycle(k == n, din[k-1]);
         if (k < n) dout[k] = bus.jtag_TDO_data;
      end
      check("drv_after_shift", 32'(bus.jtag_TDO_driven), 32'd0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      check("back_rti", 32'(bus.tap_state), 32'd1);
   endtask

   logic [31:0] dout;
   int          upd_snap;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.jtag_TCK   = 1'b0;
      bus.jtag_TMS   = 1'b0;
      bus.jtag_TDI   = 1'b0;
      bus.jtag_TRSTn = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_state", 32'(bus.tap_state), 32'd0);
      check("rst_drv", 32'(bus.jtag_TDO_driven), 32'd0);
      check("rst_tdo", 32'(bus.jtag_TDO_data), 32'd0);
      check("rst_user_dr", bus.user_dr, 32'd0);
      check("rst_user_upd", 32'(bus.user_update), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clock);

      // Five TMS=1 rises reach TLR, then TMS=0 to RTI.
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
      check("tlr_after_5", 32'(bus.tap_state), 32'd0);
      tck_cycle(1'b0, 1'b0);
      check("rti", 32'(bus.tap_state), 32'd1);
      check("rti_drv", 32'(bus.jtag_TDO_driven), 32'd0);

      // IDCODE readout after reset.
      scan(1'b0, 32'h0, 32, 0, dout);
      check("idcode", dout, 32'h0000_0001);

      // BYPASS: A5 appears one TCK late behind the captured 0.
      scan(1'b1, 32'h1F, 5, 0, dout);
      check("ir_capture_1f", dout & 32'h1F, 32'h01);
      scan(1'b0, 32'h0A5, 9, 0, dout);
      check("bypass", dout & 32'h1FF, 32'h14A);

      // USER DR write and readback.
      scan(1'b1, 32'h10, 5, 0, dout);
      check("ir_capture_10", dout & 32'h1F, 32'h01);
      check("no_upd_yet", 32'(upd_cnt), 32'd0);
      scan(1'b0, 32'hDEADBEEF, 32, 0, dout);
      check("user_old", dout, 32'h0);
      check("user_dr_wr", bus.user_dr, 32'hDEADBEEF);
      check("user_upd_once", 32'(upd_cnt), 32'd1);
      scan(1'b0, 32'hDEADBEEF, 32, 0, dout);
      check("user_readback", dout, 32'hDEADBEEF);
      check("user_upd_twice", 32'(upd_cnt), 32'd2);

      // TRST during a USER shift aborts it; user_dr kept.
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b1);
      tck_cycle(1'b0, 1'b0);
      check("pre_trst_shdr", 32'(bus.tap_state), 32'd4);
      upd_snap = upd_cnt;
      bus.jtag_TRSTn = 1'b0;
      repeat (3) @(posedge clock);
      bus.jtag_TRSTn = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("trst_state", 32'(bus.tap_state), 32'd0);
      check("trst_drv", 32'(bus.jtag_TDO_driven), 32'd0);
      check("trst_user_dr", bus.user_dr, 32'hDEADBEEF);
      check("trst_no_upd", 32'(upd_cnt), 32'(upd_snap));

      // TRST restored IDCODE instruction.
      tck_cycle(1'b0, 1'b0);
      scan(1'b0, 32'h0, 32, 0, dout);
      check("idcode_after_trst", dout, 32'h0000_0001);

      // Static TCK for 100 clocks mid-shift: no state change, no shift.
      scan(1'b1, 32'h10, 5, 0, dout);
      scan(1'b0, 32'hDEADBEEF, 32, 100, dout);
      check("hold_user_read", dout, 32'hDEADBEEF);
      check("hold_user_dr", bus.user_dr, 32'hDEADBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
